// File: rtl/cdb_pkg.sv
// Shared CDB types: ROB/value widths, result message, FU indices.
// Optional stall counter enabled by CDB_STALL_CNT_EN.
package cdb_pkg;

  localparam int ROB_W = 2;
  localparam int VAL_W = 3;

  localparam int FU_ALU = 0;
  localparam int FU_MEM = 1;
  localparam int FU_MUL = 2;

  typedef struct packed {
    logic [ROB_W-1:0] rob_idx;
    logic [VAL_W-1:0] val;
  } cdb_msg_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr wins.
// Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int j;
    j = 0;
    grant = '0;
    gnt_valid = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        grant[j] = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit holding slots, round-robin grant, registered CDB.
// Define CDB_STALL_CNT_EN to add the saturating stall_cnt output.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ROB_W = 2,
  parameter int VAL_W = 3,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ROB_W-1:0] req_rob_idx,
  input  logic [NUM_REQ*VAL_W-1:0] req_val,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     cdb_en,
  output logic [ROB_W-1:0]         cdb_rob_idx,
  output logic [VAL_W-1:0]         cdb_val,
  output logic [SRC_W-1:0]         cdb_src,
`ifdef CDB_STALL_CNT_EN
  output logic [7:0]               stall_cnt,
`endif
  output logic                     busy
);

  import cdb_pkg::*;

  cdb_msg_t           slot [NUM_REQ];
  logic [NUM_REQ-1:0] slot_v;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] xfer;
  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_idx;
  cdb_msg_t           cdb_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (slot_v),
    .ptr       (rr_ptr),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A slot draining this cycle can take new data on the same edge.
  assign req_ready = {NUM_REQ{!flush}} & (~slot_v | grant);
  assign xfer = req_valid & req_ready;
  assign busy = |slot_v;

  assign ptr_nxt = (gnt_idx == SRC_W'(NUM_REQ - 1)) ?
                   '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v  <= '0;
      rr_ptr  <= '0;
      cdb_en  <= 1'b0;
      cdb_q   <= '0;
      cdb_src <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
    end else if (flush) begin
      slot_v  <= '0;
      rr_ptr  <= '0;
      cdb_en  <= 1'b0;
      cdb_q   <= '0;
      cdb_src <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i]) begin
          slot_v[i]       <= 1'b1;
          slot[i].rob_idx <= req_rob_idx[i*ROB_W +: ROB_W];
          slot[i].val     <= req_val[i*VAL_W +: VAL_W];
        end else if (grant[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
      if (gnt_valid) begin
        cdb_en  <= 1'b1;
        cdb_q   <= slot[gnt_idx];
        cdb_src <= gnt_idx;
        rr_ptr  <= ptr_nxt;
      end else begin
        cdb_en  <= 1'b0;
        cdb_q   <= '0;
        cdb_src <= '0;
      end
    end
  end

  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_val     = cdb_q.val;

`ifdef CDB_STALL_CNT_EN
  logic multi_v;

  // Two or more set bits means some unit is waiting behind the winner.
  assign multi_v = |(slot_v & (slot_v - NUM_REQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!flush && multi_v && stall_cnt != 8'hff) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with a broadcast scoreboard.
// Stall counter checks run when CDB_STALL_CNT_EN is defined.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] req_valid = '0;
  logic [5:0] req_rob_idx = '0;
  logic [8:0] req_val = '0;
  logic [2:0] req_ready;
  logic       cdb_en;
  logic [1:0] cdb_rob_idx;
  logic [2:0] cdb_val;
  logic [1:0] cdb_src;
  logic       busy;
`ifdef CDB_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] rob;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  cdb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_rob_idx (req_rob_idx),
    .req_val     (req_val),
    .req_ready   (req_ready),
    .cdb_en      (cdb_en),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_val     (cdb_val),
    .cdb_src     (cdb_src),
`ifdef CDB_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && cdb_en) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_bcast: got src=%0d rob=%0d val=%0d, required no broadcast",
                 cdb_src, cdb_rob_idx, cdb_val);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({cdb_src, cdb_rob_idx, cdb_val} !== {e.src, e.rob, e.val}) begin
          n_fail++;
          $display("FAIL bcast: got src=%0d rob=%0d val=%0d, required src=%0d rob=%0d val=%0d",
                   cdb_src, cdb_rob_idx, cdb_val, e.src, e.rob, e.val);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] rob, input logic [2:0] val);
    req_valid[i] = 1'b1;
    req_rob_idx[i*2 +: 2] = rob;
    req_val[i*3 +: 3] = val;
  endtask

  task automatic push(input int src, input logic [1:0] rob, input logic [2:0] val);
    exp_t e;
    e.src = 2'(src);
    e.rob = rob;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic do_flush();
    @(negedge clk);
    req_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      #2;
      t++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    #2;
    n_chk++;
    if ({cdb_en, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_drain: got en=%b busy=%b, required 0 0", cdb_en, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_chk++;
    if ({cdb_en, cdb_rob_idx, cdb_val, cdb_src, busy, req_ready} !== {1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 3'b111}) begin
      n_fail++;
      $display("FAIL reset_state: got en=%b rob=%0d val=%0d src=%0d busy=%b rdy=%b, required 0 0 0 0 0 111",
               cdb_en, cdb_rob_idx, cdb_val, cdb_src, busy, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_flush();
    @(negedge clk);
    set_req(FU_ALU, 2'd2, 3'd5);
    push(FU_ALU, 2'd2, 3'd5);
    #1;
    n_chk++;
    if (req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b, required 1", req_ready[0]);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++;
    if ({cdb_en, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_latency: got en=%b busy=%b, required 0 1", cdb_en, busy);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    do_flush();
    @(negedge clk);
    set_req(FU_ALU, 2'd0, 3'd1);
    set_req(FU_MEM, 2'd1, 3'd2);
    set_req(FU_MUL, 2'd3, 3'd3);
    push(FU_ALU, 2'd0, 3'd1);
    push(FU_MEM, 2'd1, 3'd2);
    push(FU_MUL, 2'd3, 3'd3);
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (cdb_en !== (k < 3)) begin
        n_fail++;
        $display("FAIL b2b_en[%0d]: got %b, required %b", k, cdb_en, k < 3);
      end
    end
    drain();
  endtask

  task automatic run_alt(input int ncyc);
    logic ea, em;
    int   ka, km;
    ka = 0;
    km = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ea = (c == 0) || (c % 2 == 1);
      em = (c == 0) || (c % 2 == 0);
      set_req(FU_ALU, 2'(ka), 3'(ka));
      set_req(FU_MEM, 2'(km + 1), 3'(7 - km));
      #1;
      if (c < 12) begin
        n_chk++;
        if (req_ready[1:0] !== {em, ea}) begin
          n_fail++;
          $display("FAIL alt_ready[%0d]: got %b, required %b", c, req_ready[1:0], {em, ea});
        end
      end
      if (ea) begin
        push(FU_ALU, 2'(ka), 3'(ka));
        ka++;
      end
      if (em) begin
        push(FU_MEM, 2'(km + 1), 3'(7 - km));
        km++;
      end
    end
    @(negedge clk);
    req_valid = '0;
    drain();
  endtask

  task automatic test_fairness();
    do_flush();
    run_alt(8);
  endtask

  task automatic test_backpressure();
    do_flush();
    @(negedge clk);
    set_req(FU_ALU, 2'd1, 3'd3);
    set_req(FU_MUL, 2'd2, 3'd6);
    push(FU_ALU, 2'd1, 3'd3);
    push(FU_MUL, 2'd2, 3'd6);
    @(negedge clk);
    req_valid = '0;
    set_req(FU_MUL, 2'd3, 3'd4);
    #1;
    n_chk++;
    if (req_ready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_lose: got %b, required 0", req_ready[2]);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (req_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_win: got %b, required 1", req_ready[2]);
    end
    push(FU_MUL, 2'd3, 3'd4);
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_refill_busy: got %b, required 1", busy);
    end
    drain();
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_req(FU_ALU, 2'd1, 3'd1);
    set_req(FU_MEM, 2'd2, 3'd2);
    @(negedge clk);
    req_valid = '0;
    flush = 1'b1;
    #1;
    n_chk++;
    if ({busy, req_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL flush_ready: got busy=%b rdy=%b, required 1 000", busy, req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_chk++;
    if ({cdb_en, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_clear: got en=%b busy=%b, required 0 0", cdb_en, busy);
    end
    @(negedge clk);
    set_req(FU_MEM, 2'd3, 3'd6);
    push(FU_MEM, 2'd3, 3'd6);
    @(negedge clk);
    req_valid = '0;
    drain();
    do_flush();
    @(negedge clk);
    set_req(FU_ALU, 2'd0, 3'd7);
    set_req(FU_MUL, 2'd2, 3'd4);
    push(FU_ALU, 2'd0, 3'd7);
    push(FU_MUL, 2'd2, 3'd4);
    @(negedge clk);
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(FU_ALU, 2'd1, 3'd2);
    set_req(FU_MEM, 2'd2, 3'd3);
    set_req(FU_MUL, 2'd3, 3'd4);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cdb_en, cdb_rob_idx, cdb_val, busy, req_ready} !== {1'b0, 2'd0, 3'd0, 1'b0, 3'b111}) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b rob=%0d val=%0d busy=%b rdy=%b, required 0 0 0 0 111",
               cdb_en, cdb_rob_idx, cdb_val, busy, req_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CDB_STALL_CNT_EN
  task automatic test_stall_cnt();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(FU_ALU, 2'd0, 3'd1);
    set_req(FU_MEM, 2'd1, 3'd2);
    set_req(FU_MUL, 2'd2, 3'd3);
    push(FU_ALU, 2'd0, 3'd1);
    push(FU_MEM, 2'd1, 3'd2);
    push(FU_MUL, 2'd2, 3'd3);
    @(negedge clk);
    req_valid = '0;
    drain();
    n_chk++;
    if (stall_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL stall_cnt_three: got %0d, required 2", stall_cnt);
    end
    do_flush();
    run_alt(300);
    n_chk++;
    if (stall_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL stall_cnt_sat: got %0d, required 255", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef CDB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
